// File: rtl/instr_sequencer.sv
// Program sequencer: host-loaded instruction buffer, walked from address 0 on start,
// one issue per 2+WAIT_CYC cycles. Optional NOP_SKIP_EN drops all-zero-opcode words at fetch.
module instr_sequencer #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [15:0]   load_data_i,
  input  logic [AW:0]   prog_len_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [3:0]    opcode_o,
  output logic [3:0]    rd_o,
  output logic [3:0]    rs1_o,
  output logic [3:0]    rs2_o,
  output logic          issue_valid_o,
  output logic [AW-1:0] pc_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int            CW        = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  logic [15:0]   buf_q [DEPTH];
  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW:0]   len_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   ir_q;
  logic          issue_q;
  logic          busy_q;
  logic          done_q;

  logic [15:0]   ir_d;
  logic [AW:0]   len_d;
  logic          last_s;

  function automatic logic [AW:0] clamp_len(input logic [AW:0] n);
    return (n > DEPTH_L) ? DEPTH_L : n;
  endfunction

  assign ir_d   = buf_q[pc_q];
  assign len_d  = clamp_len(prog_len_i);
  assign last_s = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  // Host writes land only while the sequencer is idle; contents survive reset and abort.
  always_ff @(posedge clk) begin
    if (load_en_i && (state_q == S_IDLE)) begin
      buf_q[load_addr_i] <= load_data_i;
    end
  end

  // Sequencer FSM; the IR doubles as the registered operand outputs and is zero outside ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ir_q    <= 16'h0000;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ir_q    <= 16'h0000;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            pc_q   <= '0;
            len_q  <= len_d;
            busy_q <= 1'b1;
            if (len_d == (AW+1)'(0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
`ifdef NOP_SKIP_EN
          if (ir_d[15:12] == 4'h0) begin
            if (last_s) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_q + AW'(1);
            end
          end else begin
            ir_q    <= ir_d;
            issue_q <= 1'b1;
            state_q <= S_ISSUE;
          end
`else
          ir_q    <= ir_d;
          issue_q <= 1'b1;
          state_q <= S_ISSUE;
`endif
        end
        S_ISSUE: begin
          ir_q    <= 16'h0000;
          issue_q <= 1'b0;
          cnt_q   <= WAIT_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == CW'(0)) begin
            if (last_s) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              pc_q    <= pc_q + AW'(1);
              state_q <= S_FETCH;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          pc_q    <= '0;
          ir_q    <= 16'h0000;
          issue_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign opcode_o      = ir_q[15:12];
  assign rd_o          = ir_q[11:8];
  assign rs1_o         = ir_q[7:4];
  assign rs2_o         = ir_q[3:0];
  assign issue_valid_o = issue_q;
  assign pc_o          = pc_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
